hdca_axil_ctrl_slave: RTL and testbench

AXI4-Lite responder for the HDCA control register window at HDCA base address 0xA000_0000. It answers the control-plane master's writes and reads, which are issued one at a time through the VIP or PS. It converts register writes into core controls: a level soft reset, a one-cycle start pulse, the instruction length and the interrupt enable. It collects core busy/done status into a readable status register and a W1C interrupt register that drives irq.

---
 rtl/hdca_axil_ctrl_slave.sv | 168 ++++++++++++++++
 tb/tb_hdca_axil_ctrl_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdca_axil_ctrl_slave.sv
// AXI4-Lite control window for the HDCA core: CTRL, STATUS, IRQ_STATUS, INST_LEN, VERSION.
// B rises one edge after both AW and W are held, R one edge after AR; new requests stall until B/R is taken.
module hdca_axil_ctrl_slave #(
  parameter int          ADDR_W     = 5,
  parameter int          INST_LEN_W = 16,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic                  soft_rst,
  output logic                  start_pulse,
  output logic [INST_LEN_W-1:0] inst_len,
  output logic                  irq
);

  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_IRQ    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_LEN    = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OFF_VER    = ADDR_W'(32'h10);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  logic                  rdy_en;
  logic                  aw_full, w_full;
  logic [ADDR_W-1:0]     aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  ctrl_soft, ctrl_start, ctrl_irq_en;
  logic                  done_sts, irq_sts;
  logic [INST_LEN_W-1:0] inst_len_q;

  logic                  wr_commit, wr_ctrl, irq_clr, start_fire;
  logic                  soft_nxt, start_nxt, soft_hold;
  logic [INST_LEN_W-1:0] len_nxt;
  logic [31:0]           rd_dat;
  logic                  unused_bits;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a inside {OFF_CTRL, OFF_STATUS, OFF_IRQ, OFF_LEN, OFF_VER};
  endfunction

  // Readies stay low until the first edge after reset release.
  assign s_awready = rdy_en & ~aw_full & ~s_bvalid;
  assign s_wready  = rdy_en & ~w_full & ~s_bvalid;
  assign s_arready = rdy_en & ~s_rvalid;

  assign wr_commit  = aw_full & w_full;
  assign wr_ctrl    = wr_commit & (aw_addr == OFF_CTRL) & w_strb[0];
  assign irq_clr    = wr_commit & (aw_addr == OFF_IRQ) & w_strb[0] & w_data[0];
  assign soft_nxt   = wr_ctrl ? w_data[0] : ctrl_soft;
  assign start_nxt  = wr_ctrl ? w_data[1] : ctrl_start;
  assign start_fire = wr_ctrl & w_data[1] & ~ctrl_start & ~w_data[0];
  // Status is held clear both while soft reset is active and on the edge it is written.
  assign soft_hold  = ctrl_soft | soft_nxt;

  assign soft_rst    = ctrl_soft;
  assign inst_len    = inst_len_q;
  assign unused_bits = ^{w_data, w_strb};

  always_comb begin
    len_nxt = inst_len_q;
    for (int i = 0; i < INST_LEN_W; i++) begin
      if (wr_commit && (aw_addr == OFF_LEN) && w_strb[i/8]) len_nxt[i] = w_data[i];
    end
  end

  always_comb begin
    rd_dat = '0;
    case (s_araddr)
      OFF_CTRL:   rd_dat = {29'b0, ctrl_irq_en, ctrl_start, ctrl_soft};
      OFF_STATUS: rd_dat = {30'b0, done_sts, core_busy};
      OFF_IRQ:    rd_dat = {31'b0, irq_sts};
      OFF_LEN:    rd_dat = 32'(inst_len_q);
      OFF_VER:    rd_dat = VERSION;
      default:    rd_dat = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en      <= 1'b0;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      aw_addr     <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      s_bvalid    <= 1'b0;
      s_bresp     <= RESP_OKAY;
      s_rvalid    <= 1'b0;
      s_rdata     <= '0;
      s_rresp     <= RESP_OKAY;
      ctrl_soft   <= 1'b0;
      ctrl_start  <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done_sts    <= 1'b0;
      irq_sts     <= 1'b0;
      inst_len_q  <= INST_LEN_W'(32);
      start_pulse <= 1'b0;
      irq         <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (s_awvalid && s_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_full <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (wr_commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= addr_ok(aw_addr) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end

      ctrl_soft   <= soft_nxt;
      ctrl_start  <= start_nxt;
      if (wr_ctrl) ctrl_irq_en <= w_data[2];
      inst_len_q  <= len_nxt;
      start_pulse <= start_fire;

      // A core_done on the same edge as a W1C clear or a start wins.
      if (soft_hold) begin
        done_sts <= 1'b0;
        irq_sts  <= 1'b0;
      end else begin
        if (core_done)       done_sts <= 1'b1;
        else if (start_fire) done_sts <= 1'b0;
        if (core_done)       irq_sts  <= 1'b1;
        else if (irq_clr)    irq_sts  <= 1'b0;
      end
      irq <= ctrl_irq_en & irq_sts;

      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_dat;
        s_rresp  <= addr_ok(s_araddr) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdca_axil_ctrl_slave.sv
// Directed bench for hdca_axil_ctrl_slave: register map, start/soft-reset/irq behaviour and
// channel handshakes, with hand-computed expected values.
`timescale 1ns/1ps
module tb_hdca_axil_ctrl_slave;
  localparam int ADDR_W     = 5;
  localparam int INST_LEN_W = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [ADDR_W-1:0]     s_awaddr = '0;
  logic                  s_awvalid = 1'b0;
  logic                  s_awready;
  logic [31:0]           s_wdata = '0;
  logic [3:0]            s_wstrb = '0;
  logic                  s_wvalid = 1'b0;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready = 1'b0;
  logic [ADDR_W-1:0]     s_araddr = '0;
  logic                  s_arvalid = 1'b0;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready = 1'b0;
  logic                  core_busy = 1'b0;
  logic                  core_done = 1'b0;
  logic                  soft_rst;
  logic                  start_pulse;
  logic [INST_LEN_W-1:0] inst_len;
  logic                  irq;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  hdca_axil_ctrl_slave #(.ADDR_W(ADDR_W), .INST_LEN_W(INST_LEN_W), .VERSION(32'h0001_0000)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .core_busy(core_busy), .core_done(core_done),
    .soft_rst(soft_rst), .start_pulse(start_pulse), .inst_len(inst_len), .irq(irq)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (start_pulse) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    bit aw_ok, w_ok, aw_hs, w_hs;
    int n;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 50) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      tick();
      if (aw_hs) begin aw_ok = 1'b1; s_awvalid = 1'b0; end
      if (w_hs)  begin w_ok = 1'b1;  s_wvalid = 1'b0;  end
      n++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 50) begin tick(); n++; end
    check("wr_bvalid", s_bvalid, 1);
    resp = s_bresp;
    tick();
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1; n = 0;
    while (!s_arready && n < 50) begin tick(); n++; end
    tick();
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 50) begin tick(); n++; end
    check("rd_rvalid", s_rvalid, 1);
    d = s_rdata; resp = s_rresp;
    tick();
  endtask

  task automatic wr_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_resp);
    logic [1:0] resp;
    wr(a, d, s, resp);
    check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  resp;
    rd(a, d, resp);
    check({tag, "_rdata"}, d, exp_d);
    check({tag, "_rresp"}, 32'(resp), 32'(exp_resp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and ready release on the first edge after aresetn rises.
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_soft_rst", soft_rst, 0);
    check("rst_start", start_pulse, 0);
    check("rst_irq", irq, 0);
    check("rst_inst_len", inst_len, 32);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_awready_pre", s_awready, 0);
    tick();
    check("rel_awready", s_awready, 1);
    check("rel_wready", s_wready, 1);
    check("rel_arready", s_arready, 1);

    // 1: soft reset level
    wr_chk("t1_set", 5'h00, 32'h1, 4'hF, OKAY);
    check("t1_soft_hi", soft_rst, 1);
    repeat (5) tick();
    check("t1_soft_hold", soft_rst, 1);
    wr_chk("t1_clr", 5'h00, 32'h0, 4'hF, OKAY);
    check("t1_soft_lo", soft_rst, 0);
    check("t1_no_pulse", pulse_cnt, 0);

    // 2: start pulse on 0->1 only
    wr_chk("t2_w0", 5'h00, 32'h0, 4'hF, OKAY);
    wr_chk("t2_w2", 5'h00, 32'h2, 4'hF, OKAY);
    check("t2_one_pulse", pulse_cnt, 1);
    wr_chk("t2_w2b", 5'h00, 32'h2, 4'hF, OKAY);
    check("t2_no_repulse", pulse_cnt, 1);
    rd_chk("t2_ctrl", 5'h00, 32'h2, OKAY);

    // 3: done / irq / W1C
    wr_chk("t3_w6", 5'h00, 32'h6, 4'hF, OKAY);
    check("t3_no_pulse", pulse_cnt, 1);
    core_busy = 1'b1;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick(); tick();
    rd_chk("t3_status_busy", 5'h04, 32'h3, OKAY);
    rd_chk("t3_irqsts", 5'h08, 32'h1, OKAY);
    check("t3_irq_hi", irq, 1);
    core_busy = 1'b0;
    rd_chk("t3_status", 5'h04, 32'h2, OKAY);
    wr_chk("t3_w1c", 5'h08, 32'h1, 4'hF, OKAY);
    check("t3_irq_lo", irq, 0);
    rd_chk("t3_irqsts_clr", 5'h08, 32'h0, OKAY);
    s_awaddr = 5'h08; s_wdata = 32'h1; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    check("t3_race_awready", s_awready, 1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("t3_race_bvalid", s_bvalid, 1);
    tick();
    rd_chk("t3_race_irqsts", 5'h08, 32'h1, OKAY);
    check("t3_race_irq", irq, 1);
    wr_chk("t3_soft", 5'h00, 32'h5, 4'hF, OKAY);
    check("t3_soft_irq", irq, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick(); tick();
    rd_chk("t3_soft_irqsts", 5'h08, 32'h0, OKAY);
    rd_chk("t3_soft_status", 5'h04, 32'h0, OKAY);
    rd_chk("t3_soft_ctrl", 5'h00, 32'h5, OKAY);
    wr_chk("t3_w4", 5'h00, 32'h4, 4'hF, OKAY);
    check("t3_pulse_cnt", pulse_cnt, 1);
    check("t3_len_kept", inst_len, 32);

    // 4: W before AW, held B, AW-before-W second write
    s_bready = 1'b0;
    s_awaddr = 5'h0C; s_wdata = 32'h0000_00A5; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    check("t4_wready_full", s_wready, 0);
    check("t4_awready_idle", s_awready, 1);
    tick(); tick();
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check("t4_bvalid_early", s_bvalid, 0);
    tick();
    check("t4_bvalid", s_bvalid, 1);
    check("t4_len1", inst_len, 16'h00A5);
    s_awvalid = 1'b1; s_wdata = 32'h0000_005A;
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_bvalid", s_bvalid, 1);
      check("t4_hold_awready", s_awready, 0);
      tick();
    end
    check("t4_len_once", inst_len, 16'h00A5);
    s_bready = 1'b1;
    tick();
    check("t4_b_done", s_bvalid, 0);
    s_bready = 1'b0;
    check("t4_aw2_ready", s_awready, 1);
    tick();
    s_awvalid = 1'b0;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    tick();
    check("t4_b2", s_bvalid, 1);
    check("t4_len2", inst_len, 16'h005A);
    s_bready = 1'b1;
    tick();
    check("t4_b2_done", s_bvalid, 0);

    // 5: strobes, RO, undecoded offsets
    wr_chk("t5_len", 5'h0C, 32'hFFFF_0080, 4'b0001, OKAY);
    check("t5_inst_len", inst_len, 16'h0080);
    rd_chk("t5_len_rd", 5'h0C, 32'h0000_0080, OKAY);
    rd_chk("t5_ver", 5'h10, 32'h0001_0000, OKAY);
    rd_chk("t5_bad_rd", 5'h14, 32'h0, SLVERR);
    wr_chk("t5_bad_wr", 5'h1C, 32'h1234, 4'hF, SLVERR);
    wr_chk("t5_ro_wr", 5'h10, 32'hDEAD, 4'hF, OKAY);
    rd_chk("t5_ver2", 5'h10, 32'h0001_0000, OKAY);

    // read and write committing on the same edge: read sees the old value
    s_awaddr = 5'h0C; s_wdata = 32'h11; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 5'h0C; s_arvalid = 1'b1;
    check("t5_col_arready", s_arready, 1);
    tick();
    s_arvalid = 1'b0;
    check("t5_col_rvalid", s_rvalid, 1);
    check("t5_col_rdata", s_rdata, 32'h80);
    check("t5_col_bvalid", s_bvalid, 1);
    check("t5_col_len", inst_len, 16'h0011);
    tick();
    check("t5_col_rdone", s_rvalid, 0);
    check("t5_col_bdone", s_bvalid, 0);

    // 6: reset while R is pending
    s_rready = 1'b0;
    s_araddr = 5'h00; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check("t6_rvalid", s_rvalid, 1);
    check("t6_rdata", s_rdata, 32'h4);
    tick(); tick();
    check("t6_rvalid_held", s_rvalid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_rvalid_rst", s_rvalid, 0);
    check("t6_len_rst", inst_len, 32);
    check("t6_arready_rst", s_arready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    rd_chk("t6_ctrl", 5'h00, 32'h0, OKAY);
    rd_chk("t6_len", 5'h0C, 32'h20, OKAY);
    rd_chk("t6_irqsts", 5'h08, 32'h0, OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
